// File: rtl/ex313_pkg.sv
// Constants and state type shared by the EX_313 forward pipeline and its inverse,
// so both ends agree on the offset and widths.
package ex313_pkg;

  localparam int unsigned EX313_WI = 8;
  localparam int unsigned EX313_WG = 16;
  localparam logic [15:0] EX313_OFFSET = 16'h004E;

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    DONE
  } state_t;

endpackage

// File: rtl/ex313_mac_inverse_div_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// subtract the divisor if it fits, and report the quotient bit.
module ex313_div_step #(
  parameter int unsigned WI = 8
) (
  input  logic [WI:0]   rem,
  input  logic          next_bit,
  input  logic [WI-1:0] divisor,
  output logic [WI:0]   rem_out,
  output logic          q_bit
);

  logic [WI:0] shifted;
  logic [WI:0] diff;

  // rem[WI] is always 0 after a restoring step; folding it into the
  // compare keeps the step correct for any input.
  assign shifted = {rem[WI-1:0], next_bit};
  assign diff    = shifted - {1'b0, divisor};
  assign q_bit   = rem[WI] | (shifted >= {1'b0, divisor});
  assign rem_out = q_bit ? diff : shifted;

endmodule

// File: rtl/ex313_mac_inverse.sv
// Receive-side inverse of g = a*b + c + OFFSET: recovers a and c from g and b
// with a bit-serial restoring divider behind a start/ready/valid handshake.
module ex313_mac_inverse
  import ex313_pkg::*;
#(
  parameter int unsigned   WI     = EX313_WI,
  parameter int unsigned   WG     = EX313_WG,
  parameter logic [WG-1:0] OFFSET = WG'(EX313_OFFSET)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [WG-1:0] g_in,
  input  logic [WI-1:0] b_in,
  output logic          ready,
  output logic          out_valid,
  output logic [WI-1:0] a_out,
  output logic [WI-1:0] c_out,
  output logic          q_ovf,
  output logic          div_zero,
  output logic          underflow
);

  localparam int unsigned CW = (WG > 1) ? $clog2(WG) : 1;

  state_t        state, state_next;
  logic [WG-1:0] tq;
  logic [WG-1:0] q_next;
  logic [WG-1:0] t_in;
  logic [WI:0]   rem, rem_next;
  logic [WI-1:0] divisor;
  logic [CW-1:0] cnt;
  logic          q_bit;
  logic          last;
  logic          err_zero;
  logic          err_uf;

  assign err_zero = (b_in == '0);
  assign err_uf   = (g_in < OFFSET);
  assign t_in     = g_in - OFFSET;
  assign last     = (cnt == CW'(WG - 1));
  // tq holds the unconsumed dividend bits on top and the quotient grown from the bottom
  assign q_next   = {tq[WG-2:0], q_bit};

  ex313_div_step #(.WI(WI)) u_step (
    .rem     (rem),
    .next_bit(tq[WG-1]),
    .divisor (divisor),
    .rem_out (rem_next),
    .q_bit   (q_bit)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    ready      = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) state_next = (err_zero || err_uf) ? DONE : DIV;
      end
      DIV:  if (last) state_next = DONE;
      DONE: begin
        out_valid  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tq        <= '0;
      rem       <= '0;
      divisor   <= '0;
      cnt       <= '0;
      a_out     <= '0;
      c_out     <= '0;
      q_ovf     <= 1'b0;
      div_zero  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            tq      <= (err_zero || err_uf) ? '0 : t_in;
            divisor <= b_in;
            cnt     <= '0;
            rem     <= '0;
            if (err_zero || err_uf) begin
              a_out     <= '0;
              c_out     <= '0;
              q_ovf     <= 1'b0;
              div_zero  <= err_zero;
              underflow <= err_uf;
            end
          end
        end
        DIV: begin
          tq  <= q_next;
          rem <= rem_next;
          cnt <= cnt + CW'(1);
          // Results are registered on the final step so DONE presents them directly.
          if (last) begin
            a_out     <= q_next[WI-1:0];
            c_out     <= rem_next[WI-1:0];
            q_ovf     <= |q_next[WG-1:WI];
            div_zero  <= 1'b0;
            underflow <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ex313_mac_inverse.sv
// Self-checking bench for ex313_mac_inverse: vector table, random vectors against a
// divide/modulo model, and hand sequences for ignored start and mid-divide reset.
module tb_ex313_mac_inverse;

  typedef struct {
    logic [15:0] g;
    logic [7:0]  b;
    logic [7:0]  a;
    logic [7:0]  c;
    logic        ovf;
    logic        dz;
    logic        uf;
    int          cyc;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] g_in;
  logic [7:0]  b_in;
  logic        ready;
  logic        out_valid;
  logic [7:0]  a_out;
  logic [7:0]  c_out;
  logic        q_ovf;
  logic        div_zero;
  logic        underflow;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  vec_t exp_q[$];
  vec_t last_exp;
  bit   hold_pending = 1'b0;

  ex313_mac_inverse dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .g_in     (g_in),
    .b_in     (b_in),
    .ready    (ready),
    .out_valid(out_valid),
    .a_out    (a_out),
    .c_out    (c_out),
    .q_ovf    (q_ovf),
    .div_zero (div_zero),
    .underflow(underflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [15:0] g, input logic [7:0] b, input logic [7:0] a,
                              input logic [7:0] c, input logic ovf, input logic dz, input logic uf);
    vec_t v;
    v.g = g; v.b = b; v.a = a; v.c = c;
    v.ovf = ovf; v.dz = dz; v.uf = uf; v.cyc = 0;
    return v;
  endfunction

  function automatic vec_t model(input logic [15:0] g, input logic [7:0] b);
    int unsigned t, q, r;
    if (b == 0 || g < 16'h004E)
      return mk(g, b, 8'h00, 8'h00, 1'b0, b == 0, g < 16'h004E);
    t = int'(g) - 32'h4E;
    q = t / b;
    r = t % b;
    return mk(g, b, q[7:0], r[7:0], q > 255, 1'b0, 1'b0);
  endfunction

  // Scoreboard side: every valid pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (reset && out_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid: got out_valid=1 expected no pending request (t=%0t)", $time);
      end else begin
        vec_t e;
        e = exp_q.pop_front();
        check("latency", cyc - e.cyc, (e.dz || e.uf) ? 1 : 17);
        check("result", {a_out, c_out, q_ovf, div_zero, underflow},
              {e.a, e.c, e.ovf, e.dz, e.uf});
        last_exp     = e;
        hold_pending = 1'b1;
      end
    end else if (reset && hold_pending) begin
      hold_pending = 1'b0;
      check("hold", {out_valid, a_out, c_out, q_ovf, div_zero, underflow},
            {1'b0, last_exp.a, last_exp.c, last_exp.ovf, last_exp.dz, last_exp.uf});
    end
  end

  task automatic issue(input vec_t v, input bit track);
    int n = 0;
    @(negedge clk);
    while (!ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", ready, 1);
    start = 1'b1;
    g_in  = v.g;
    b_in  = v.b;
    v.cyc = cyc;
    if (track) exp_q.push_back(v);
    @(negedge clk);
    start = 1'b0;
    g_in  = 16'($urandom);
    b_in  = 8'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain", exp_q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    vec_t vt[10];
    vec_t v1;
    vt[0] = mk(16'h0074, 8'd7,   8'd5,   8'd3,   1'b0, 1'b0, 1'b0);
    vt[1] = mk(16'hFF4D, 8'd255, 8'd255, 8'd254, 1'b0, 1'b0, 1'b0);
    vt[2] = mk(16'hFFFF, 8'd1,   8'hB1,  8'd0,   1'b1, 1'b0, 1'b0);
    vt[3] = mk(16'h1234, 8'd0,   8'd0,   8'd0,   1'b0, 1'b1, 1'b0);
    vt[4] = mk(16'h0010, 8'd3,   8'd0,   8'd0,   1'b0, 1'b0, 1'b1);
    vt[5] = mk(16'h0010, 8'd0,   8'd0,   8'd0,   1'b0, 1'b1, 1'b1);
    vt[6] = mk(16'h004E, 8'd5,   8'd0,   8'd0,   1'b0, 1'b0, 1'b0);
    vt[7] = mk(16'h004D, 8'd5,   8'd0,   8'd0,   1'b0, 1'b0, 1'b1);
    vt[8] = mk(16'h0100, 8'd16,  8'd11,  8'd2,   1'b0, 1'b0, 1'b0);
    vt[9] = mk(16'h034E, 8'd3,   8'd0,   8'd0,   1'b1, 1'b0, 1'b0);
    v1 = vt[0];

    reset = 1'b0;
    start = 1'b0;
    g_in  = '0;
    b_in  = '0;
    repeat (3) @(negedge clk);
    check("reset_state", {ready, out_valid, a_out, c_out, q_ovf, div_zero, underflow},
          {1'b1, 1'b0, 8'd0, 8'd0, 3'b000});
    reset = 1'b1;

    foreach (vt[i]) issue(vt[i], 1'b1);
    drain();

    for (int i = 0; i < 8; i++) begin
      logic [15:0] rg;
      logic [7:0]  rb;
      rg = 16'($urandom);
      rb = 8'($urandom_range(1, 255));
      issue(model(rg, rb), 1'b1);
    end
    drain();

    // A start while busy must be dropped, not queued.
    issue(v1, 1'b1);
    check("busy_ready", ready, 0);
    start = 1'b1;
    g_in  = 16'h1234;
    b_in  = 8'd0;
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (20) @(negedge clk);

    // Reset in the middle of a divide aborts it with no result afterwards.
    issue(v1, 1'b0);
    repeat (8) @(posedge clk);
    #2 reset = 1'b0;
    #1 check("abort_state", {ready, out_valid, a_out, c_out, q_ovf, div_zero, underflow},
             {1'b1, 1'b0, 8'd0, 8'd0, 3'b000});
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (25) @(negedge clk);
    check("post_abort_ready", ready, 1);
    issue(v1, 1'b1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
